// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer (MAIN + SKID) for a pipeline stage payload; ready never depends on out_ready_i.
// Optional synchronous flush_i input when PIPE_FLUSH_EN is defined.
module pipe_skid_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
`ifdef PIPE_FLUSH_EN
  input  logic              flush_i,
`endif
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] res_i,
  input  logic [DATA_W-1:0] sdata_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [DATA_W-1:0] res_o,
  output logic [DATA_W-1:0] sdata_o,
  output logic [1:0]        occ_o
);

  localparam int PAY_W = CTRL_W + ADDR_W + 2 * DATA_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state_reg;
  logic [PAY_W-1:0]   main_reg;
  logic [PAY_W-1:0]   skid_reg;
  logic [PAY_W-1:0]   in_data;
  logic               accept;
  logic               emit;

  assign in_data = {ctrl_i, rd_addr_i, res_i, sdata_i};

  // Ready is also held low during reset so every output reads zero then.
  assign in_ready_o  = start_i & ~rst_i & (state_reg != FULL);
  assign out_valid_o = start_i & (state_reg != EMPTY);
  assign accept      = in_valid_i & in_ready_o;
  assign emit        = out_valid_o & out_ready_i;

  assign ctrl_o    = out_valid_o ? main_reg[PAY_W-1 -: CTRL_W] : '0;
  assign rd_addr_o = main_reg[2*DATA_W +: ADDR_W];
  assign res_o     = main_reg[DATA_W +: DATA_W];
  assign sdata_o   = main_reg[0 +: DATA_W];
  assign occ_o     = state_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
`ifdef PIPE_FLUSH_EN
    end else if (flush_i) begin
      state_reg <= EMPTY;
`endif
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            main_reg  <= in_data;
            state_reg <= ONE;
          end
        end
        ONE: begin
          if (accept && emit) begin
            main_reg <= in_data;
          end else if (accept) begin
            skid_reg  <= in_data;
            state_reg <= FULL;
          end else if (emit) begin
            state_reg <= EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            main_reg  <= skid_reg;
            state_reg <= ONE;
          end
        end
        default: state_reg <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and randomized-handshake checks for pipe_skid_stage; define PIPE_FLUSH_EN to exercise flush.
module tb_pipe_skid_stage;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 4;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] ctrl_in;
  logic [ADDR_W-1:0] rd_addr_in;
  logic [DATA_W-1:0] res_in;
  logic [DATA_W-1:0] sdata_in;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] ctrl_out;
  logic [ADDR_W-1:0] rd_addr_out;
  logic [DATA_W-1:0] res_out;
  logic [DATA_W-1:0] sdata_out;
  logic [1:0]        occ;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .ADDR_W(ADDR_W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
`ifdef PIPE_FLUSH_EN
    .flush_i    (flush),
`endif
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .ctrl_i     (ctrl_in),
    .rd_addr_i  (rd_addr_in),
    .res_i      (res_in),
    .sdata_i    (sdata_in),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .ctrl_o     (ctrl_out),
    .rd_addr_o  (rd_addr_out),
    .res_o      (res_out),
    .sdata_o    (sdata_out),
    .occ_o      (occ)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [DATA_W-1:0] r, input logic [CTRL_W-1:0] c);
    in_valid   = v;
    res_in     = r;
    ctrl_in    = c;
    rd_addr_in = r[ADDR_W-1:0];
    sdata_in   = ~r;
  endtask

  // Stream model state
  logic [CTRL_W+ADDR_W+DATA_W-1:0] exp_q[$];
  int model_occ;
  int sent;
  int got;
  int cyc;
  logic exp_in_ready;
  logic exp_out_valid;
  logic [DATA_W-1:0] sres;

  initial begin
    rst = 1'b1; start = 1'b1; flush = 1'b0; out_ready = 1'b1;
    offer(1'b0, '0, '0);
    step(); step();
    check("rst_occ", 64'(occ), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_ctrl", 64'(ctrl_out), 64'd0);
    check("rst_res", 64'(res_out), 64'd0);
    rst = 1'b0;

    // Single payload, one-cycle latency
    offer(1'b1, 32'h1234, 4'b1001);
    #1 check("t1_in_ready", 64'(in_ready), 64'd1);
    step();
    offer(1'b0, '0, '0);
    check("t1_out_valid", 64'(out_valid), 64'd1);
    check("t1_res", 64'(res_out), 64'h1234);
    check("t1_ctrl", 64'(ctrl_out), 64'b1001);
    check("t1_occ", 64'(occ), 64'd1);
    $display("t1 emit res=%h ctrl=%b", res_out, ctrl_out);
    step();
    check("t1_occ_after", 64'(occ), 64'd0);
    check("t1_bubble_ctrl", 64'(ctrl_out), 64'd0);
    check("t1_hold_res", 64'(res_out), 64'h1234);

    // Back-pressure: A, B fill, C refused, then drain in order
    out_ready = 1'b0;
    offer(1'b1, 32'hA, 4'h1);
    #1 check("t2_rdy_a", 64'(in_ready), 64'd1);
    step();
    offer(1'b1, 32'hB, 4'h2);
    #1 check("t2_rdy_b", 64'(in_ready), 64'd1);
    step();
    offer(1'b1, 32'hC, 4'h3);
    #1 check("t2_rdy_c", 64'(in_ready), 64'd0);
    check("t2_occ_full", 64'(occ), 64'd2);
    step();
    out_ready = 1'b1;
    #1 check("t2_emit_a", 64'(res_out), 64'hA);
    check("t2_rdy_full", 64'(in_ready), 64'd0);
    $display("t2 emit res=%h", res_out);
    step();
    check("t2_emit_b", 64'(res_out), 64'hB);
    check("t2_occ_one", 64'(occ), 64'd1);
    check("t2_rdy_one", 64'(in_ready), 64'd1);
    $display("t2 emit res=%h", res_out);
    step();
    offer(1'b0, '0, '0);
    #1 check("t2_emit_c", 64'(res_out), 64'hC);
    check("t2_ctrl_c", 64'(ctrl_out), 64'h3);
    $display("t2 emit res=%h", res_out);
    step();
    check("t2_occ_empty", 64'(occ), 64'd0);

    // Freeze while FULL
    out_ready = 1'b0;
    offer(1'b1, 32'hD, 4'h4); step();
    offer(1'b1, 32'hE, 4'h5); step();
    start = 1'b0; out_ready = 1'b1;
    offer(1'b1, 32'hF0, 4'h6);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t3_frz_valid", 64'(out_valid), 64'd0);
      check("t3_frz_ready", 64'(in_ready), 64'd0);
      check("t3_frz_occ", 64'(occ), 64'd2);
      check("t3_frz_ctrl", 64'(ctrl_out), 64'd0);
      step();
    end
    start = 1'b1;
    offer(1'b0, '0, '0);
    #1 check("t3_emit_d", 64'(res_out), 64'hD);
    check("t3_ctrl_d", 64'(ctrl_out), 64'h4);
    $display("t3 emit res=%h", res_out);
    step();
    check("t3_emit_e", 64'(res_out), 64'hE);
    check("t3_occ_one", 64'(occ), 64'd1);
    $display("t3 emit res=%h", res_out);
    step();
    check("t3_occ_empty", 64'(occ), 64'd0);

    // Asynchronous reset while ONE
    out_ready = 1'b0;
    offer(1'b1, 32'h55, 4'h7); step();
    offer(1'b0, '0, '0);
    #1 check("t4_occ_one", 64'(occ), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t4_arst_occ", 64'(occ), 64'd0);
    check("t4_arst_valid", 64'(out_valid), 64'd0);
    check("t4_arst_res", 64'(res_out), 64'd0);
    check("t4_arst_ctrl", 64'(ctrl_out), 64'd0);
    check("t4_arst_ready", 64'(in_ready), 64'd0);
    #1 rst = 1'b0;
    step();
    out_ready = 1'b1;
    offer(1'b1, 32'h66, 4'h8);
    #1 check("t4_rdy", 64'(in_ready), 64'd1);
    step();
    offer(1'b0, '0, '0);
    check("t4_res_g", 64'(res_out), 64'h66);
    check("t4_occ_g", 64'(occ), 64'd1);
    step();
    check("t4_occ_empty", 64'(occ), 64'd0);

`ifdef PIPE_FLUSH_EN
    // Flush while FULL with an offered payload, start low
    out_ready = 1'b0;
    offer(1'b1, 32'h71, 4'h1); step();
    offer(1'b1, 32'h72, 4'h2); step();
    check("t5_occ_full", 64'(occ), 64'd2);
    start = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; start = 1'b1;
    offer(1'b0, '0, '0);
    #1;
    check("t5_occ", 64'(occ), 64'd0);
    check("t5_valid", 64'(out_valid), 64'd0);
    check("t5_ctrl", 64'(ctrl_out), 64'd0);
    step();
`endif

    // Streaming with random handshakes against an occupancy/queue model
    model_occ = 0; sent = 0; got = 0; cyc = 0;
    while (got < 100 && cyc < 3000) begin
      sres = 32'hA000_0000 + 32'(sent);
      offer((sent < 100) && ($urandom_range(3) != 0), sres, 4'((sent % 15) + 1));
      out_ready = (sent >= 100) ? 1'b1 : 1'($urandom_range(1));
      #1;
      exp_in_ready  = (model_occ != 2);
      exp_out_valid = (model_occ != 0);
      check("s_in_ready", 64'(in_ready), 64'(exp_in_ready));
      check("s_out_valid", 64'(out_valid), 64'(exp_out_valid));
      check("s_occ", 64'(occ), 64'(model_occ));
      if (exp_out_valid && out_ready) begin
        check("s_data", 64'({ctrl_out, rd_addr_out, res_out}), 64'(exp_q[0]));
        $display("stream emit %0d res=%h ctrl=%h", got, res_out, ctrl_out);
        void'(exp_q.pop_front());
        got++;
        model_occ--;
      end
      if (in_valid && exp_in_ready) begin
        exp_q.push_back({ctrl_in, rd_addr_in, res_in});
        sent++;
        model_occ++;
      end
      step();
      cyc++;
    end
    check("s_count", 64'(got), 64'd100);
    offer(1'b0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter DATA_W, default 32; width of the result and store-data payload fields.
REQ-002 Parameter CTRL_W, default 4; width of the control bundle (bit0 RegWrite, bit1 MemReg, bit2 MemRead, bit3 MemWrite).
REQ-003 Parameter ADDR_W, default 5; width of the destination register address.
REQ-004 clk_i  in  1  clock; all state changes on the rising edge.
REQ-005 rst_i  in  1  reset; asynchronous, active-high.
REQ-006 start_i  in  1  global run enable; 0 freezes the stage.
REQ-007 in_valid_i  in  1  upstream payload valid.
REQ-008 in_ready_o  out  1  stage can accept a payload.
REQ-009 ctrl_i / rd_addr_i / res_i / sdata_i  in  CTRL_W / ADDR_W / DATA_W / DATA_W  upstream payload.
REQ-010 out_valid_o  out  1  downstream payload valid.
REQ-011 out_ready_i  in  1  downstream accepts.
REQ-012 ctrl_o / rd_addr_o / res_o / sdata_o  out  CTRL_W / ADDR_W / DATA_W / DATA_W  downstream payload.
REQ-013 occ_o  out  2  entries held (0, 1 or 2).
REQ-014 flush_i  in  1  synchronous discard of all held entries; present only with PIPE_FLUSH_EN.

Function
REQ-015 Storage SHALL be two entries: MAIN (drives outputs) and SKID (overflow); state EMPTY, ONE or FULL.
REQ-016 in_ready_o SHALL equal start_i AND (state != FULL), with no combinational path from out_ready_i.
REQ-017 out_valid_o SHALL equal start_i AND (state != EMPTY).
REQ-018 Accept SHALL occur when in_valid_i and in_ready_o are both 1; emit SHALL occur when out_valid_o and out_ready_i are both 1.
REQ-019 EMPTY: on accept, the payload is loaded into MAIN and the state moves to ONE; latency from input to output is 1 cycle.
REQ-020 ONE: on accept with emit, the payload is loaded into MAIN and the state stays ONE; on accept without emit, the payload is loaded into SKID and the state moves to FULL; on emit without accept, the state moves to EMPTY.
REQ-021 FULL: on emit, SKID moves into MAIN and the state moves to ONE; no accept is possible in FULL.
REQ-022 Payloads SHALL leave in acceptance order; none is dropped or duplicated.
REQ-023 When out_valid_o is 0, ctrl_o SHALL be all zero (bubble); rd_addr_o, res_o and sdata_o hold their last value.
REQ-024 With start_i=0, no accept, emit or state change SHALL occur, and stored payloads SHALL be retained.
REQ-025 occ_o SHALL be 0, 1 or 2 for EMPTY, ONE or FULL respectively, and is not gated by start_i.

Reset
REQ-026 While rst_i=1 and immediately on its assertion: state is EMPTY, MAIN and SKID are zero, all outputs are 0, and occ_o is 0.
REQ-027 Reset asserted mid-transfer SHALL discard all held entries; the first accept after release behaves as from EMPTY.

Configuration
REQ-028 Macro PIPE_FLUSH_EN defined: the flush_i port exists.
REQ-029 With PIPE_FLUSH_EN, flush_i=1 at an edge SHALL force state EMPTY at that edge, discarding any same-cycle accept.
REQ-030 With PIPE_FLUSH_EN, flush SHALL take effect regardless of start_i.
REQ-031 With PIPE_FLUSH_EN, in_ready_o and out_valid_o SHALL NOT depend on flush_i combinationally.
REQ-032 Macro PIPE_FLUSH_EN undefined: the flush_i port and flush logic are absent; all other behaviour is unchanged.

Verification
REQ-033 Reset, then start_i=1 and a single payload with res_i=0x1234, ctrl_i=4'b1001, out_ready_i=1 -> out_valid_o=1 one cycle later with res_o=0x1234 and ctrl_o=4'b1001, then occ_o returns to 0.
REQ-034 out_ready_i=0 while A, B, C are offered back to back -> A and B accepted, occ_o=2, in_ready_o=0 for C; release out_ready_i -> A, B, C emitted in order.
REQ-035 Streaming 100 payloads with out_ready_i toggled randomly -> output sequence equals input sequence, and no cycle shows in_ready_o=1 in FULL.
REQ-036 start_i=0 for 5 cycles while FULL with out_ready_i=1 -> no emits, occ_o stays 2, payloads intact; start_i=1 -> drains in order.
REQ-037 With PIPE_FLUSH_EN, flush_i=1 while FULL and in_valid_i=1 -> next cycle occ_o=0, out_valid_o=0, ctrl_o=0.
REQ-038 rst_i pulsed asynchronously mid-cycle while ONE -> outputs zero before the next clock edge and occ_o=0.
